// File: rtl/sisc_prog_loader.sv
// -----------------------------------------------------------------------------
// sisc_prog_loader
//
// Byte-serial program loader for the SISC instruction memory. Bytes from an
// external source are packed big-endian into 32-bit words and written into
// `im` starting at BASE_ADDR. A trailing checksum byte, the XOR of all data
// bytes, decides whether the image is accepted. The SISC core stays in reset
// (cpu_hold=1) until an image has been loaded and verified.
//
// Ports:
//   clk         system clock, rising edge
//   rst_f       synchronous active-high reset
//   start       one-cycle pulse starting a load (honoured in IDLE/DONE/ERR)
//   word_count  number of 32-bit words in the image, sampled on start
//   byte_in     stream data byte
//   byte_valid  byte_in carries a valid byte
//   byte_ready  loader accepts a byte this cycle
//   im_we       one-cycle im write strobe
//   im_addr     im word address
//   im_wdata    im write data
//   cpu_hold    holds the SISC core in reset while 1
//   done        image loaded and checksum verified
//   err         checksum mismatch
// -----------------------------------------------------------------------------
module sisc_prog_loader #(
   parameter logic [15:0] BASE_ADDR = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_f,
   input  logic        start,
   input  logic [15:0] word_count,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic        byte_ready,
   output logic        im_we,
   output logic [15:0] im_addr,
   output logic [31:0] im_wdata,
   output logic        cpu_hold,
   output logic        done,
   output logic        err
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_CHECK,
      ST_DONE,
      ST_ERR
   } state_t;

   state_t      r_state;
   logic [15:0] r_remaining;
   logic [15:0] r_ptr;
   logic [1:0]  r_byteIdx;
   logic [23:0] r_word;
   logic [7:0]  r_xor;

   logic w_accept;
   logic w_startOk;

   // A byte moves only on a valid/ready handshake; start is only honoured
   // while no load is in progress.
   assign w_accept  = byte_valid && byte_ready;
   assign w_startOk = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                (r_state == ST_ERR));

   // Loader state machine. All outputs are registered here; byte_ready is
   // set on entry to LOAD/CHECK so it is high exactly while those states are
   // active. im_addr only moves when a write is issued, which keeps it stable
   // across the write strobe while r_ptr already points at the next word.
   always_ff @(posedge clk) begin
      if (rst_f) begin
         r_state     <= ST_IDLE;
         r_remaining <= 16'h0000;
         r_ptr       <= BASE_ADDR;
         r_byteIdx   <= 2'd0;
         r_word      <= 24'h000000;
         r_xor       <= 8'h00;
         byte_ready  <= 1'b0;
         im_we       <= 1'b0;
         im_addr     <= BASE_ADDR;
         im_wdata    <= 32'h00000000;
         cpu_hold    <= 1'b1;
         done        <= 1'b0;
         err         <= 1'b0;
      end else begin
         im_we <= 1'b0;
         case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
               if (w_startOk) begin
                  r_remaining <= word_count;
                  r_ptr       <= BASE_ADDR;
                  r_byteIdx   <= 2'd0;
                  r_xor       <= 8'h00;
                  byte_ready  <= 1'b1;
                  cpu_hold    <= 1'b1;
                  done        <= 1'b0;
                  err         <= 1'b0;
                  r_state     <= (word_count == 16'h0000) ? ST_CHECK : ST_LOAD;
               end
            end

            ST_LOAD: begin
               if (w_accept) begin
                  r_xor     <= r_xor ^ byte_in;
                  r_byteIdx <= r_byteIdx + 2'd1;
                  if (r_byteIdx == 2'd3) begin
                     im_we       <= 1'b1;
                     im_addr     <= r_ptr;
                     im_wdata    <= {r_word, byte_in};
                     r_ptr       <= r_ptr + 16'h0001;
                     r_remaining <= r_remaining - 16'h0001;
                     if (r_remaining == 16'h0001) begin
                        r_state <= ST_CHECK;
                     end
                  end else begin
                     r_word <= {r_word[15:0], byte_in};
                  end
               end
            end

            ST_CHECK: begin
               if (w_accept) begin
                  byte_ready <= 1'b0;
                  if (byte_in == r_xor) begin
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                     r_state  <= ST_DONE;
                  end else begin
                     err     <= 1'b1;
                     r_state <= ST_ERR;
                  end
               end
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sisc_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_sisc_prog_loader
//
// Self-checking bench for sisc_prog_loader. Two instances share all inputs:
// dut0 with BASE_ADDR=0000 and dut1 with BASE_ADDR=FFFF for address wrap.
// Expected writes and checksums come from a word-list reference model.
// -----------------------------------------------------------------------------
module tb_sisc_prog_loader;

   logic        clk = 1'b0;
   logic        rst_f = 1'b1;
   logic        start = 1'b0;
   logic [15:0] word_count = 16'h0000;
   logic [7:0]  byte_in = 8'h00;
   logic        byte_valid = 1'b0;

   logic        byteReady0, imWe0, cpuHold0, done0, err0;
   logic [15:0] imAddr0;
   logic [31:0] imWdata0;
   logic        byteReady1, imWe1, cpuHold1, done1, err1;
   logic [15:0] imAddr1;
   logic [31:0] imWdata1;

   int nChecks = 0;
   int nPass = 0;
   int cycle = 0;

   logic [31:0] stimWords[$];
   logic [7:0]  streamBytes[$];
   logic [15:0] wrAddr0[$];
   logic [31:0] wrData0[$];
   int          wrCyc0[$];
   logic [15:0] wrAddr1[$];
   logic [31:0] wrData1[$];

   sisc_prog_loader #(.BASE_ADDR(16'h0000)) dut0 (
      .clk(clk), .rst_f(rst_f), .start(start), .word_count(word_count),
      .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byteReady0),
      .im_we(imWe0), .im_addr(imAddr0), .im_wdata(imWdata0),
      .cpu_hold(cpuHold0), .done(done0), .err(err0)
   );

   sisc_prog_loader #(.BASE_ADDR(16'hFFFF)) dut1 (
      .clk(clk), .rst_f(rst_f), .start(start), .word_count(word_count),
      .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byteReady1),
      .im_we(imWe1), .im_addr(imAddr1), .im_wdata(imWdata1),
      .cpu_hold(cpuHold1), .done(done1), .err(err1)
   );

   always #5 clk = ~clk;

   // Write monitor: logs every cycle in which a write strobe is seen.
   always @(negedge clk) begin
      if (imWe0) begin
         wrAddr0.push_back(imAddr0);
         wrData0.push_back(imWdata0);
         wrCyc0.push_back(cycle);
      end
      if (imWe1) begin
         wrAddr1.push_back(imAddr1);
         wrData1.push_back(imWdata1);
      end
      cycle++;
   end

   // Reference model: checksum is the XOR of every data byte of the image.
   function automatic logic [7:0] modelXor();
      logic [7:0] x = 8'h00;
      foreach (stimWords[i]) begin
         x = x ^ stimWords[i][31:24] ^ stimWords[i][23:16] ^
             stimWords[i][15:8] ^ stimWords[i][7:0];
      end
      return x;
   endfunction

   // Serialise the image big-endian and append the chosen checksum byte.
   task automatic buildStream(input logic [7:0] chk);
      streamBytes.delete();
      foreach (stimWords[i]) begin
         streamBytes.push_back(stimWords[i][31:24]);
         streamBytes.push_back(stimWords[i][23:16]);
         streamBytes.push_back(stimWords[i][15:8]);
         streamBytes.push_back(stimWords[i][7:0]);
      end
      streamBytes.push_back(chk);
   endtask

   task automatic clearLog();
      wrAddr0.delete(); wrData0.delete(); wrCyc0.delete();
      wrAddr1.delete(); wrData1.delete();
   endtask

   // Pulse start for one cycle; returns at the falling edge after the start
   // edge, then scrambles word_count to show it was latched.
   task automatic pulseStart(input int wc);
      @(negedge clk);
      start = 1'b1;
      word_count = wc[15:0];
      @(negedge clk);
      start = 1'b0;
      word_count = 16'($urandom);
   endtask

   // Drive nBytes of streamBytes through the handshake. Junk is driven on
   // cycles with valid low. Optionally fires an (ignored) start mid-stream.
   task automatic feedBytes(input int nBytes, input bit randValid,
                            input int startAt, output bit timedOut);
      int idx = 0;
      int budget = 0;
      bit acc;
      bit fired = 1'b0;
      while (idx < nBytes && budget < 2000) begin
         byte_valid = randValid ? 1'($urandom_range(0, 1)) : 1'b1;
         byte_in = byte_valid ? streamBytes[idx] : 8'($urandom);
         if (idx == startAt && !fired) begin
            start = 1'b1;
            word_count = 16'd7;
            fired = 1'b1;
         end else begin
            start = 1'b0;
         end
         acc = byte_valid && byteReady0;
         @(negedge clk);
         if (acc) idx++;
         budget++;
      end
      byte_valid = 1'b0;
      start = 1'b0;
      timedOut = (idx < nBytes);
   endtask

   task automatic applyStimulus(input int nWords);
      stimWords.delete();
      for (int i = 0; i < nWords; i++) stimWords.push_back($urandom);
   endtask

   task automatic test_reset();
      rst_f = 1'b1;
      repeat (2) @(negedge clk);
      nChecks++; if (byteReady0 !== 1'b0) $display("[TB] FAIL reset_ready got %b want 0", byteReady0); else nPass++;
      nChecks++; if (imWe0 !== 1'b0) $display("[TB] FAIL reset_we got %b want 0", imWe0); else nPass++;
      nChecks++; if (imAddr0 !== 16'h0000) $display("[TB] FAIL reset_addr got %h want 0000", imAddr0); else nPass++;
      nChecks++; if (imAddr1 !== 16'hFFFF) $display("[TB] FAIL reset_addr1 got %h want ffff", imAddr1); else nPass++;
      nChecks++; if (imWdata0 !== 32'h0) $display("[TB] FAIL reset_wdata got %h want 0", imWdata0); else nPass++;
      nChecks++; if (cpuHold0 !== 1'b1) $display("[TB] FAIL reset_hold got %b want 1", cpuHold0); else nPass++;
      nChecks++; if (done0 !== 1'b0 || err0 !== 1'b0) $display("[TB] FAIL reset_flags got done=%b err=%b want 0/0", done0, err0); else nPass++;
      rst_f = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      bit to;
      stimWords.delete();
      stimWords.push_back(32'h10000005);
      stimWords.push_back(32'h20010003);
      buildStream(modelXor());
      clearLog();
      pulseStart(2);
      nChecks++; if (byteReady0 !== 1'b1) $display("[TB] FAIL basic_ready_rise got %b want 1", byteReady0); else nPass++;
      nChecks++; if (cpuHold0 !== 1'b1) $display("[TB] FAIL basic_hold_loading got %b want 1", cpuHold0); else nPass++;
      feedBytes(streamBytes.size(), 1'b0, -1, to);
      nChecks++; if (to) $display("[TB] FAIL basic_timeout got timeout want stream consumed"); else nPass++;
      nChecks++; if (wrAddr0.size() !== 2) $display("[TB] FAIL basic_nwrites got %0d want 2", wrAddr0.size()); else nPass++;
      for (int i = 0; i < 2 && i < wrAddr0.size(); i++) begin
         nChecks++; if (wrAddr0[i] !== 16'(i)) $display("[TB] FAIL basic_addr%0d got %h want %h", i, wrAddr0[i], 16'(i)); else nPass++;
         nChecks++; if (wrData0[i] !== stimWords[i]) $display("[TB] FAIL basic_data%0d got %h want %h", i, wrData0[i], stimWords[i]); else nPass++;
      end
      if (wrCyc0.size() == 2) begin
         nChecks++; if (wrCyc0[1] - wrCyc0[0] !== 4) $display("[TB] FAIL back_to_back_spacing got %0d want 4", wrCyc0[1] - wrCyc0[0]); else nPass++;
      end
      nChecks++; if (done0 !== 1'b1 || err0 !== 1'b0) $display("[TB] FAIL basic_done got done=%b err=%b want 1/0", done0, err0); else nPass++;
      nChecks++; if (cpuHold0 !== 1'b0) $display("[TB] FAIL basic_release got %b want 0", cpuHold0); else nPass++;
      nChecks++; if (byteReady0 !== 1'b0) $display("[TB] FAIL basic_ready_fall got %b want 0", byteReady0); else nPass++;
   endtask

   task automatic test_bad_checksum();
      bit to;
      stimWords.delete();
      stimWords.push_back(32'h10000005);
      stimWords.push_back(32'h20010003);
      buildStream(8'h00);
      pulseStart(2);
      nChecks++; if (done0 !== 1'b0 || cpuHold0 !== 1'b1) $display("[TB] FAIL reload_clears got done=%b hold=%b want 0/1", done0, cpuHold0); else nPass++;
      feedBytes(streamBytes.size(), 1'b0, -1, to);
      nChecks++; if (err0 !== 1'b1 || done0 !== 1'b0) $display("[TB] FAIL bad_err got err=%b done=%b want 1/0", err0, done0); else nPass++;
      nChecks++; if (cpuHold0 !== 1'b1) $display("[TB] FAIL bad_hold got %b want 1", cpuHold0); else nPass++;
      repeat (3) @(negedge clk);
      nChecks++; if (err0 !== 1'b1) $display("[TB] FAIL bad_err_sticky got %b want 1", err0); else nPass++;
      buildStream(modelXor());
      pulseStart(2);
      nChecks++; if (err0 !== 1'b0) $display("[TB] FAIL retry_err_clear got %b want 0", err0); else nPass++;
      feedBytes(streamBytes.size(), 1'b0, -1, to);
      nChecks++; if (done0 !== 1'b1 || err0 !== 1'b0 || cpuHold0 !== 1'b0) $display("[TB] FAIL retry_done got done=%b err=%b hold=%b want 1/0/0", done0, err0, cpuHold0); else nPass++;
   endtask

   task automatic test_zero_words();
      bit to;
      stimWords.delete();
      buildStream(modelXor());
      clearLog();
      pulseStart(0);
      nChecks++; if (byteReady0 !== 1'b1) $display("[TB] FAIL zero_ready got %b want 1", byteReady0); else nPass++;
      feedBytes(1, 1'b0, -1, to);
      nChecks++; if (wrAddr0.size() !== 0) $display("[TB] FAIL zero_nwrites got %0d want 0", wrAddr0.size()); else nPass++;
      nChecks++; if (done0 !== 1'b1 || cpuHold0 !== 1'b0) $display("[TB] FAIL zero_done got done=%b hold=%b want 1/0", done0, cpuHold0); else nPass++;
   endtask

   task automatic test_random_valid();
      bit to;
      for (int rep = 0; rep < 3; rep++) begin
         applyStimulus(3);
         buildStream(modelXor());
         clearLog();
         pulseStart(3);
         feedBytes(streamBytes.size(), 1'b1, 5, to);
         nChecks++; if (to) $display("[TB] FAIL rand_timeout got timeout want stream consumed"); else nPass++;
         nChecks++; if (wrAddr0.size() !== 3) $display("[TB] FAIL rand_nwrites got %0d want 3", wrAddr0.size()); else nPass++;
         for (int i = 0; i < 3 && i < wrAddr0.size(); i++) begin
            nChecks++; if (wrAddr0[i] !== 16'(i) || wrData0[i] !== stimWords[i]) $display("[TB] FAIL rand_write%0d got %h@%h want %h@%h", i, wrData0[i], wrAddr0[i], stimWords[i], 16'(i)); else nPass++;
            if (i > 0) begin
               nChecks++; if (wrCyc0[i] - wrCyc0[i-1] < 4) $display("[TB] FAIL rand_pulse_spacing got %0d want >=4", wrCyc0[i] - wrCyc0[i-1]); else nPass++;
            end
         end
         nChecks++; if (done0 !== 1'b1 || err0 !== 1'b0) $display("[TB] FAIL rand_done got done=%b err=%b want 1/0", done0, err0); else nPass++;
      end
   endtask

   task automatic test_wrap();
      bit to;
      applyStimulus(2);
      buildStream(modelXor());
      clearLog();
      pulseStart(2);
      feedBytes(streamBytes.size(), 1'b0, -1, to);
      nChecks++; if (wrAddr1.size() !== 2) $display("[TB] FAIL wrap_nwrites got %0d want 2", wrAddr1.size()); else nPass++;
      if (wrAddr1.size() == 2) begin
         nChecks++; if (wrAddr1[0] !== 16'hFFFF || wrData1[0] !== stimWords[0]) $display("[TB] FAIL wrap_first got %h@%h want %h@ffff", wrData1[0], wrAddr1[0], stimWords[0]); else nPass++;
         nChecks++; if (wrAddr1[1] !== 16'h0000 || wrData1[1] !== stimWords[1]) $display("[TB] FAIL wrap_second got %h@%h want %h@0000", wrData1[1], wrAddr1[1], stimWords[1]); else nPass++;
      end
      nChecks++; if (done1 !== 1'b1) $display("[TB] FAIL wrap_done got %b want 1", done1); else nPass++;
   endtask

   task automatic test_reset_midload();
      bit to;
      applyStimulus(3);
      buildStream(modelXor());
      pulseStart(3);
      feedBytes(6, 1'b0, -1, to);
      rst_f = 1'b1;
      @(negedge clk);
      nChecks++; if (byteReady0 !== 1'b0 || imWe0 !== 1'b0 || imAddr0 !== 16'h0000 || imWdata0 !== 32'h0)
         $display("[TB] FAIL midrst_outputs got rdy=%b we=%b addr=%h wd=%h want 0/0/0000/0", byteReady0, imWe0, imAddr0, imWdata0); else nPass++;
      nChecks++; if (cpuHold0 !== 1'b1 || done0 !== 1'b0 || err0 !== 1'b0)
         $display("[TB] FAIL midrst_flags got hold=%b done=%b err=%b want 1/0/0", cpuHold0, done0, err0); else nPass++;
      rst_f = 1'b0;
      applyStimulus(3);
      buildStream(modelXor());
      clearLog();
      pulseStart(3);
      feedBytes(streamBytes.size(), 1'b0, -1, to);
      nChecks++; if (wrAddr0.size() !== 3) $display("[TB] FAIL midrst_nwrites got %0d want 3", wrAddr0.size()); else nPass++;
      for (int i = 0; i < 3 && i < wrAddr0.size(); i++) begin
         nChecks++; if (wrAddr0[i] !== 16'(i) || wrData0[i] !== stimWords[i]) $display("[TB] FAIL midrst_write%0d got %h@%h want %h@%h", i, wrData0[i], wrAddr0[i], stimWords[i], 16'(i)); else nPass++;
      end
      nChecks++; if (done0 !== 1'b1 || err0 !== 1'b0) $display("[TB] FAIL midrst_done got done=%b err=%b want 1/0", done0, err0); else nPass++;
   endtask

   // Hard stop in case the run gets stuck somewhere outside a bounded loop.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog got no end of test want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_basic();
      test_bad_checksum();
      test_zero_words();
      test_random_valid();
      test_wrap();
      test_reset_midload();
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
